fifo_level: RTL and testbench

- Parametrised synchronous FIFO with a full occupancy counter, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Show-ahead read: head word is visible on o_r_data while not empty.
- Drop-in buffer between UART rx/tx and consumers that need back-pressure before the hard full/empty limits.

---
 rtl/fifo_regfile.sv | 29 ++
 rtl/fifo_level.sv | 118 +++++++++++
 tb/tb_fifo_level.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_regfile.sv
// Storage array for fifo_level: one synchronous write port and one
// asynchronous read port, so the word at the read address is visible
// in the same cycle the address is presented.
module fifo_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming word on the clock edge; contents are never reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with occupancy counter, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags
// and a synchronous flush that outranks read and write requests.
module fifo_level #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_rd,
  input  logic              i_flush,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_r_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = ADDR_W + 1;

  // Thresholds must leave a non-empty band between almost-empty and almost-full
  if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("fifo_level: illegal thresholds AE_THRESH=%0d AF_THRESH=%0d DEPTH=%0d",
           AE_THRESH, AF_THRESH, DEPTH);
  end

  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic empty, full;
  logic wr_ok, rd_ok;
  logic ovf_set, unf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == PTR_W'(DEPTH));

  // Accept decisions, error detection and next-state for pointers, count and flags
  always_comb begin
    wr_ok   = i_wr & (~full | i_rd) & ~i_flush;
    rd_ok   = i_rd & ~empty & ~i_flush;
    ovf_set = i_wr & full & ~i_rd & ~i_flush;
    unf_set = i_rd & empty & ~i_flush;

    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;

    if (i_flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + PTR_W'(1);
      if (rd_ok) r_ptr_d = r_ptr_q + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + PTR_W'(1);
        2'b01:   count_d = count_q - PTR_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A new error event outranks a clear arriving in the same cycle
    overflow_d  = ovf_set | (overflow_q  & ~i_clr_err);
    underflow_d = unf_set | (underflow_q & ~i_clr_err);
  end

  // State registers with asynchronous return to the empty, error-free state
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // On a full read+write the old head is presented combinationally, so it
  // leaves before the write edge reuses its slot.
  fifo_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_we    (wr_ok),
    .i_waddr (w_ptr_q[ADDR_W-1:0]),
    .i_wdata (i_w_data),
    .i_raddr (r_ptr_q[ADDR_W-1:0]),
    .o_rdata (o_r_data)
  );

  assign o_empty        = empty;
  assign o_full         = full;
  assign o_almost_empty = (count_q <= PTR_W'(AE_THRESH));
  assign o_almost_full  = (count_q >= PTR_W'(AF_THRESH));
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level (DATA_W=8, ADDR_W=4, AF=12, AE=2) using a queue-based
// reference model and scenario tasks plus a randomized traffic run.
module tb_fifo_level;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_wr;
  logic [7:0] i_w_data;
  logic       i_rd;
  logic       i_flush;
  logic       i_clr_err;
  logic [7:0] o_r_data;
  logic       o_empty;
  logic       o_full;
  logic       o_almost_empty;
  logic       o_almost_full;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: contents as a queue plus the two sticky flags
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_unf;

  fifo_level #(
    .DATA_W    (8),
    .ADDR_W    (4),
    .AF_THRESH (12),
    .AE_THRESH (2)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_wr           (i_wr),
    .i_w_data       (i_w_data),
    .i_rd           (i_rd),
    .i_flush        (i_flush),
    .i_clr_err      (i_clr_err),
    .o_r_data       (o_r_data),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_almost_empty (o_almost_empty),
    .o_almost_full  (o_almost_full),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  wire [10:0] status_act = {o_count, o_empty, o_full, o_almost_empty,
                            o_almost_full, o_overflow, o_underflow};

  // Expected status derived from the model occupancy and flags
  function automatic logic [10:0] exp_status();
    int n;
    n = q.size();
    return {5'(n), n == 0, n == 16, n <= 2, n >= 12, m_ovf, m_unf};
  endfunction

  // Apply one cycle of requests, advance the model at the edge, sample 1 ns later
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd,
                       input logic fl, input logic clr);
    int   n;
    logic e, f, os, us;
    i_wr = wr; i_w_data = d; i_rd = rd; i_flush = fl; i_clr_err = clr;
    @(posedge i_clk);
    n  = q.size();
    e  = (n == 0);
    f  = (n == 16);
    os = 1'b0;
    us = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      os = wr && f && !rd;
      us = rd && e;
      if (rd && !e) void'(q.pop_front());
      if (wr && (!f || rd)) q.push_back(d);
    end
    m_ovf = os | (m_ovf & ~clr);
    m_unf = us | (m_unf & ~clr);
    #1;
    i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
  endtask

  // Pulse reset between clock edges and reset the model
  task automatic apply_reset();
    i_reset_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #3;
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if (status_act !== 11'b00000_1_0_1_0_0_0)
      $display("FAIL reset_status: got %b expected %b", status_act, 11'b00000_1_0_1_0_0_0);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b;
    apply_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({o_count, o_empty, o_almost_empty} !== {5'd3, 1'b0, 1'b0})
      $display("FAIL basic_fill: got cnt=%0d e=%b ae=%b expected cnt=3 e=0 ae=0",
               o_count, o_empty, o_almost_empty);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      exp_b = 8'(i);
      total_cnt++;
      if (o_r_data !== exp_b)
        $display("FAIL basic_head%0d: got %h expected %h", i, o_r_data, exp_b);
      else pass_cnt++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    total_cnt++;
    if ({o_empty, o_almost_empty} !== 2'b11)
      $display("FAIL basic_drain: got e=%b ae=%b expected e=1 ae=1", o_empty, o_almost_empty);
    else pass_cnt++;
  endtask

  task automatic test_full_overflow();
    logic exp_af;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
      exp_af = (i + 1 >= 12);
      total_cnt++;
      if (o_almost_full !== exp_af)
        $display("FAIL full_af_at_%0d: got %b expected %b", i + 1, o_almost_full, exp_af);
      else pass_cnt++;
    end
    total_cnt++;
    if (o_full !== 1'b1) $display("FAIL full_flag: got %b expected 1", o_full);
    else pass_cnt++;
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({o_overflow, o_count, o_r_data} !== {1'b1, 5'd16, 8'hA0})
      $display("FAIL overflow: got ovf=%b cnt=%0d head=%h expected ovf=1 cnt=16 head=a0",
               o_overflow, o_count, o_r_data);
    else pass_cnt++;
  endtask

  task automatic test_full_rdwr();
    logic [7:0] last;
    last = 8'h00;
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({o_r_data, o_count, o_full} !== {8'hA1, 5'd16, 1'b1})
      $display("FAIL full_rdwr: got head=%h cnt=%0d full=%b expected head=a1 cnt=16 full=1",
               o_r_data, o_count, o_full);
    else pass_cnt++;
    total_cnt++;
    if (status_act !== exp_status())
      $display("FAIL full_rdwr_status: got %b expected %b", status_act, exp_status());
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      last = o_r_data;
      total_cnt++;
      if (o_r_data !== q[0]) $display("FAIL full_drain_%0d: got %h expected %h", i, o_r_data, q[0]);
      else pass_cnt++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    total_cnt++;
    if ({last, o_empty} !== {8'h55, 1'b1})
      $display("FAIL full_last_word: got %h e=%b expected 55 e=1", last, o_empty);
    else pass_cnt++;
  endtask

  task automatic test_empty_rdwr();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({o_underflow, o_count, o_r_data} !== {1'b1, 5'd1, 8'h77})
      $display("FAIL empty_rdwr: got unf=%b cnt=%0d head=%h expected unf=1 cnt=1 head=77",
               o_underflow, o_count, o_r_data);
    else pass_cnt++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if ({o_overflow, o_underflow} !== 2'b00)
      $display("FAIL clr_err: got ovf=%b unf=%b expected 0 0", o_overflow, o_underflow);
    else pass_cnt++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if ({o_underflow, o_count} !== {1'b1, 5'd0})
      $display("FAIL set_beats_clr: got unf=%b cnt=%0d expected unf=1 cnt=0", o_underflow, o_count);
    else pass_cnt++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if ({o_count, o_empty, o_overflow, o_underflow} !== {5'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL flush: got cnt=%0d e=%b ovf=%b unf=%b expected cnt=0 e=1 ovf=0 unf=0",
               o_count, o_empty, o_overflow, o_underflow);
    else pass_cnt++;
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (o_underflow !== 1'b0) $display("FAIL flush_masks_unf: got %b expected 0", o_underflow);
    else pass_cnt++;
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({o_r_data, o_count} !== {8'h11, 5'd1})
      $display("FAIL after_flush: got head=%h cnt=%0d expected head=11 cnt=1", o_r_data, o_count);
    else pass_cnt++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic       seen_full;
    logic [7:0] v;
    seen_full = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      total_cnt++;
      if (o_r_data !== q[0]) $display("FAIL wrap_order_%0d: got %h expected %h", i, o_r_data, q[0]);
      else pass_cnt++;
      cycle(1'b1, v, 1'b1, 1'b0, 1'b0);
      if (o_full === 1'b1) seen_full = 1'b1;
    end
    total_cnt++;
    if ({seen_full, o_count} !== {1'b0, 5'd3})
      $display("FAIL wrap_level: got full_seen=%b cnt=%0d expected full_seen=0 cnt=3", seen_full, o_count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (o_r_data !== q[0]) $display("FAIL wrap_drain_%0d: got %h expected %h", i, o_r_data, q[0]);
      else pass_cnt++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (o_count !== 5'd7) $display("FAIL areset_pre: got cnt=%0d expected 7", o_count);
    else pass_cnt++;
    #3;
    i_reset_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    total_cnt++;
    if (status_act !== 11'b00000_1_0_1_0_0_0)
      $display("FAIL areset_immediate: got %b expected %b", status_act, 11'b00000_1_0_1_0_0_0);
    else pass_cnt++;
    #2;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({o_r_data, o_count} !== {8'h3C, 5'd1})
      $display("FAIL areset_after: got head=%h cnt=%0d expected head=3c cnt=1", o_r_data, o_count);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int   wr_pct;
    int   n_bad;
    logic wr, rd, fl, clr;
    n_bad = 0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      wr_pct = ((i / 100) % 2 == 0) ? 75 : 25;
      wr  = ($urandom_range(0, 99) < wr_pct);
      rd  = ($urandom_range(0, 99) < 50);
      fl  = ($urandom_range(0, 99) < 2);
      clr = ($urandom_range(0, 99) < 5);
      cycle(wr, 8'($urandom), rd, fl, clr);
      total_cnt++;
      if (status_act !== exp_status()) begin
        if (n_bad < 10)
          $display("FAIL rand_status_%0d: got %b expected %b", i, status_act, exp_status());
        n_bad++;
      end else pass_cnt++;
      if (q.size() != 0) begin
        total_cnt++;
        if (o_r_data !== q[0]) begin
          if (n_bad < 10) $display("FAIL rand_head_%0d: got %h expected %h", i, o_r_data, q[0]);
          n_bad++;
        end else pass_cnt++;
      end
    end
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_wr = 1'b0; i_w_data = 8'h00; i_rd = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge i_clk);
    #1;
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_rdwr();
    test_empty_rdwr();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
